// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer: free-running fetch, branch redirect with one-cycle flush,
// and branch-and-link with a held r14 write handshake.
//   state     | meaning
//   INIT      | single idle cycle after reset release, no fetch
//   RUN       | normal fetch/decode advance, branches resolved here
//   FLUSH     | one cycle discarding the wrong-path instruction in decode
//   LINK_WAIT | fetch paused while the r14 link write is waiting for ack
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [10:0] BRANCH_CODE = 11'd31,
  parameter logic [10:0] BL_CODE     = 11'd32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        dec_valid,
  input  logic [10:0] alu_ctl_code,
  input  logic [23:0] br_offset,
  input  logic        r14_ack,
  output logic [31:0] pc,
  output logic [31:0] dec_pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        r14_we,
  output logic [31:0] r14_wdata
);

  typedef enum logic [1:0] {
    INIT      = 2'd0,
    RUN       = 2'd1,
    FLUSH     = 2'd2,
    LINK_WAIT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dec_pc_q, dec_pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        flush_q, flush_d;
  logic        r14_we_q, r14_we_d;
  logic [31:0] r14_wdata_q, r14_wdata_d;

  logic [31:0] br_target;
  logic        take_br;
  logic        take_bl;

  // Offsets are relative to the instruction in decode, not the fetch address.
  assign br_target = dec_pc_q + {{8{br_offset[23]}}, br_offset};
  assign take_br   = dec_valid && (alu_ctl_code == BRANCH_CODE);
  assign take_bl   = dec_valid && (alu_ctl_code == BL_CODE);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    dec_pc_d      = dec_pc_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = flush_q;
    r14_we_d      = r14_we_q;
    r14_wdata_d   = r14_wdata_q;
    case (state_q)
      INIT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
        flush_d       = 1'b0;
      end
      RUN: begin
        if (!stall_i) begin
          dec_pc_d = pc_q;
          if (take_br) begin
            pc_d    = br_target;
            state_d = FLUSH;
            flush_d = 1'b1;
          end else if (take_bl) begin
            pc_d          = br_target;
            state_d       = LINK_WAIT;
            flush_d       = 1'b1;
            fetch_valid_d = 1'b0;
            r14_we_d      = 1'b1;
            r14_wdata_d   = dec_pc_q + 32'd1;
          end else begin
            pc_d = pc_q + 32'd1;
          end
        end
      end
      FLUSH: begin
        state_d       = RUN;
        flush_d       = 1'b0;
        fetch_valid_d = 1'b1;
        if (!stall_i) begin
          pc_d     = pc_q + 32'd1;
          dec_pc_d = pc_q;
        end
      end
      LINK_WAIT: begin
        flush_d = 1'b0;
        if (r14_ack) begin
          r14_we_d      = 1'b0;
          state_d       = RUN;
          fetch_valid_d = 1'b1;
        end
      end
      default: begin
        state_d       = INIT;
        fetch_valid_d = 1'b0;
        flush_d       = 1'b0;
        r14_we_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      pc_q          <= RESET_PC;
      dec_pc_q      <= RESET_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      r14_we_q      <= 1'b0;
      r14_wdata_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      dec_pc_q      <= dec_pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      r14_we_q      <= r14_we_d;
      r14_wdata_q   <= r14_wdata_d;
    end
  end

  assign pc          = pc_q;
  assign dec_pc      = dec_pc_q;
  assign fetch_valid = fetch_valid_q;
  assign flush       = flush_q;
  assign r14_we      = r14_we_q;
  assign r14_wdata   = r14_wdata_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each stimulus row queues the outputs
// expected in that cycle; a monitor pops and compares on the falling edge.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        dec_valid;
  logic [10:0] alu_ctl_code;
  logic [23:0] br_offset;
  logic        r14_ack;
  logic [31:0] pc;
  logic [31:0] dec_pc;
  logic        fetch_valid;
  logic        flush;
  logic        r14_we;
  logic [31:0] r14_wdata;

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .dec_valid    (dec_valid),
    .alu_ctl_code (alu_ctl_code),
    .br_offset    (br_offset),
    .r14_ack      (r14_ack),
    .pc           (pc),
    .dec_pc       (dec_pc),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .r14_we       (r14_we),
    .r14_wdata    (r14_wdata)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] dec;
    logic        fv;
    logic        fl;
    logic        we;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (pc !== e.pc || dec_pc !== e.dec || fetch_valid !== e.fv ||
          flush !== e.fl || r14_we !== e.we || r14_wdata !== e.wd) begin
        n_bad++;
        $display("FAIL %s: got pc=%h dec=%h fv=%b fl=%b we=%b wd=%h, want pc=%h dec=%h fv=%b fl=%b we=%b wd=%h",
                 e.name, pc, dec_pc, fetch_valid, flush, r14_we, r14_wdata,
                 e.pc, e.dec, e.fv, e.fl, e.we, e.wd);
      end
    end
  end

  task automatic push(input string nm, input logic [31:0] epc, input logic [31:0] edec,
                      input logic efv, input logic efl, input logic ewe, input logic [31:0] ewd);
    exp_t e;
    e.name = nm; e.pc = epc; e.dec = edec; e.fv = efv; e.fl = efl; e.we = ewe; e.wd = ewd;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic st, input logic dv, input logic [10:0] cd,
                       input logic [23:0] of, input logic ak);
    stall_i = st; dec_valid = dv; alu_ctl_code = cd; br_offset = of; r14_ack = ak;
  endtask

  // Row = outputs expected in this cycle + inputs applied for the next edge.
  task automatic step(input string nm, input logic st, input logic dv, input logic [10:0] cd,
                      input logic [23:0] of, input logic ak,
                      input logic [31:0] epc, input logic [31:0] edec, input logic efv,
                      input logic efl, input logic ewe, input logic [31:0] ewd);
    @(posedge clk);
    #1;
    push(nm, epc, edec, efv, efl, ewe, ewd);
    drive(st, dv, cd, of, ak);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 11'd0, 24'd0, 1'b0);
    #1;
    push("rst_async", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push("init", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 11'd0, 24'd0, 1'b0);
    do_reset();

    step("run0", 0, 0, 11'd0, 24'd0, 0, 32'd0, 32'd0, 1, 0, 0, 32'd0);
    for (int i = 1; i < 10; i++)
      step("ramp", 0, 0, 11'd0, 24'd0, 0, i, i - 1, 1, 0, 0, 32'd0);
    step("br_take",  0, 1, 11'd31, 24'hFFFFFC, 0, 32'd10, 32'd9, 1, 0, 0, 32'd0);
    step("flush1",   0, 1, 11'd31, 24'h000010, 0, 32'd5, 32'd10, 1, 1, 0, 32'd0);
    step("stall0",   1, 1, 11'd31, 24'd2, 0, 32'd6, 32'd5, 1, 0, 0, 32'd0);
    step("stall1",   1, 1, 11'd31, 24'd2, 0, 32'd6, 32'd5, 1, 0, 0, 32'd0);
    step("stall2",   1, 1, 11'd31, 24'd2, 0, 32'd6, 32'd5, 1, 0, 0, 32'd0);
    step("unstall",  0, 1, 11'd31, 24'd2, 0, 32'd6, 32'd5, 1, 0, 0, 32'd0);
    step("fl_stall", 1, 0, 11'd0, 24'd0, 0, 32'd7, 32'd6, 1, 1, 0, 32'd0);
    step("post_fls", 0, 0, 11'd0, 24'd0, 0, 32'd7, 32'd6, 1, 0, 0, 32'd0);
    step("br2",      0, 1, 11'd31, 24'd668, 0, 32'd8, 32'd7, 1, 0, 0, 32'd0);
    step("fl2",      0, 0, 11'd0, 24'd0, 0, 32'd675, 32'd8, 1, 1, 0, 32'd0);
    step("bl_take",  0, 1, 11'd32, 24'd600, 0, 32'd676, 32'd675, 1, 0, 0, 32'd0);
    step("lw1",      1, 1, 11'd31, 24'd5, 0, 32'd1275, 32'd676, 0, 1, 1, 32'd676);
    step("lw2",      1, 0, 11'd0, 24'd0, 0, 32'd1275, 32'd676, 0, 0, 1, 32'd676);
    step("lw3",      1, 0, 11'd0, 24'd0, 1, 32'd1275, 32'd676, 0, 0, 1, 32'd676);
    step("lw_done",  0, 0, 11'd0, 24'd0, 1, 32'd1275, 32'd676, 1, 0, 0, 32'd676);
    step("ack_ign",  0, 0, 11'd0, 24'd0, 0, 32'd1276, 32'd1275, 1, 0, 0, 32'd676);
    step("br3",      0, 1, 11'd31, 24'hFFFB02, 0, 32'd1277, 32'd1276, 1, 0, 0, 32'd676);
    step("fl3",      0, 0, 11'd0, 24'd0, 0, 32'hFFFFFFFE, 32'd1277, 1, 1, 0, 32'd676);
    step("wrap",     0, 0, 11'd0, 24'd0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0, 0, 32'd676);
    step("br4",      0, 1, 11'd31, 24'hFFFFFF, 0, 32'd0, 32'hFFFFFFFF, 1, 0, 0, 32'd676);
    step("fl4",      0, 0, 11'd0, 24'd0, 0, 32'hFFFFFFFE, 32'd0, 1, 1, 0, 32'd676);
    step("br5",      0, 1, 11'd31, 24'd3, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0, 0, 32'd676);
    step("fl5",      0, 0, 11'd0, 24'd0, 0, 32'd1, 32'hFFFFFFFF, 1, 1, 0, 32'd676);
    step("bl2",      0, 1, 11'd32, 24'd5, 0, 32'd2, 32'd1, 1, 0, 0, 32'd676);
    step("lw_a",     0, 0, 11'd0, 24'd0, 0, 32'd6, 32'd2, 0, 1, 1, 32'd2);

    do_reset();
    step("run0b", 0, 0, 11'd0, 24'd0, 0, 32'd0, 32'd0, 1, 0, 0, 32'd0);
    step("run1b", 0, 0, 11'd0, 24'd0, 0, 32'd1, 32'd0, 1, 0, 0, 32'd0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'd0: PC value loaded by reset.
REQ-002 Parameter BRANCH_CODE, default 11'd31: ALU control code for plain branch.
REQ-003 Parameter BL_CODE, default 11'd32: ALU control code for branch-and-link.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 stall_i  input  1  hazard stall; freezes fetch and decode advance.
REQ-007 dec_valid  input  1  decode stage holds a valid instruction.
REQ-008 alu_ctl_code  input  11  control code of the instruction in decode.
REQ-009 br_offset  input  24  signed word offset of the branch in decode.
REQ-010 r14_ack  input  1  register-file port accepts the link write.
REQ-011 pc  output  32  fetch address (word-indexed), registered.
REQ-012 dec_pc  output  32  PC of the instruction in decode, registered.
REQ-013 fetch_valid  output  1  fetch at pc is valid this cycle.
REQ-014 flush  output  1  discard the instruction in decode this cycle.
REQ-015 r14_we  output  1  link write request, held until acknowledged.
REQ-016 r14_wdata  output  32  link value, stable while r14_we=1.

Function
REQ-017 States SHALL be INIT, RUN, FLUSH and LINK_WAIT, encoded in a registered state vector.
REQ-018 INIT SHALL last exactly one cycle after reset release, with fetch_valid=0, and then SHALL go to RUN.
REQ-019 fetch_valid SHALL be 1 in RUN and FLUSH, and 0 in INIT and LINK_WAIT.
REQ-020 "Advance" SHALL mean fetch_valid=1 and stall_i=0; on advance, dec_pc <= pc.
REQ-021 In RUN on advance, when no branch is taken, pc SHALL become pc+1 (modulo 2^32).
REQ-022 A branch SHALL be taken in RUN when stall_i=0, dec_valid=1 and alu_ctl_code equals BRANCH_CODE or BL_CODE.
REQ-023 For a taken branch, pc SHALL become dec_pc + sign_extend_32(br_offset) (modulo 2^32); dec_pc <= pc as on advance.
REQ-024 A taken BRANCH_CODE branch SHALL go to FLUSH.
REQ-025 A taken BL_CODE branch SHALL go to LINK_WAIT and, at the same edge, set r14_we=1 and r14_wdata <= dec_pc+1.
REQ-026 FLUSH SHALL last exactly one cycle regardless of stall_i, with flush=1, and SHALL return to RUN; pc advances in FLUSH only if stall_i=0.
REQ-027 In LINK_WAIT, flush SHALL be 1 in the first cycle only; pc and dec_pc SHALL hold.
REQ-028 In LINK_WAIT, r14_we SHALL stay 1 until a cycle with r14_ack=1; the next edge SHALL clear r14_we and enter RUN; stall_i SHALL NOT affect the handshake.
REQ-029 alu_ctl_code, br_offset and dec_valid SHALL be ignored in INIT, FLUSH and LINK_WAIT.
REQ-030 When stall_i=1 in RUN, pc, dec_pc and state SHALL hold, and no branch SHALL be taken.
REQ-031 r14_wdata SHALL change only when r14_we rises.
REQ-032 flush SHALL be 0 in INIT and RUN.
REQ-033 r14_ack while r14_we=0 SHALL be ignored.

Reset
REQ-034 While rst_n=0, outputs SHALL be immediately and asynchronously forced to: state=INIT, pc=RESET_PC, dec_pc=RESET_PC, fetch_valid=0, flush=0, r14_we=0, r14_wdata=0.
REQ-035 Reset asserted during LINK_WAIT SHALL abandon the link write (r14_we=0) with no further effect.

Verification
REQ-036 Reset release, dec_valid=0, no stall, 4 cycles -> fetch_valid=0 in the first cycle, then pc=0,1,2,3.
REQ-037 pc=10, dec_pc=9, code=31, offset=24'hFFFFFC (-4) -> next pc=5, flush=1 for one cycle, r14_we stays 0.
REQ-038 dec_pc=675, code=32, offset=600, r14_ack low for 2 cycles -> pc=1275 held, r14_we=1 and r14_wdata=676 for 3 cycles, fetch_valid=0, flush=1 in the first cycle only.
REQ-039 stall_i=1 with code=31 valid for 3 cycles -> pc and dec_pc unchanged, no flush; after stall drops, the branch is taken.
REQ-040 pc=32'hFFFFFFFF advancing -> pc=0; dec_pc=32'hFFFFFFFE, offset=+3 -> target 1.
REQ-041 rst_n pulsed low mid LINK_WAIT -> r14_we=0 and pc=RESET_PC immediately, then the INIT cycle.
